// File: rtl/rca_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : rca_seq_pkg                                               |
// | Purpose  : Shared types and defaults for the sliced RCA sequencer.   |
// | Revision : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
package rca_seq_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SLICE_W_DEF = 4;
  localparam int NSLICE_DEF  = 4;

  // Slice index width; never below one bit so NSLICE=1 still has a counter
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rca_seq_ctrl_rca.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : rca_seq_ctrl_rca                                          |
// | Purpose  : Plain WIDTH-bit ripple-carry adder, purely combinational. |
// | Revision : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module rca_seq_ctrl_rca #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  // One full adder per bit, carry rippling upward
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/rca_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : rca_seq_ctrl                                              |
// | Purpose  : Adds two SLICE_W*NSLICE-bit operands through one shared   |
// |            SLICE_W-bit RCA, one slice per clock, LSB slice first,    |
// |            with valid/ready handshakes on both sides.                |
// | Options  : RCA_SEQ_SUB_EN - adds in_sub port for A-B operation.      |
// | Revision : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEF,
  parameter int NSLICE  = NSLICE_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SLICE_W*NSLICE-1:0]   in_a,
  input  logic [SLICE_W*NSLICE-1:0]   in_b,
  input  logic                        in_cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic                        in_sub,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SLICE_W*NSLICE-1:0]   out_sum,
  output logic                        out_cout
);

  localparam int OPW   = SLICE_W * NSLICE;
  localparam int IDX_W = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [OPW-1:0]     a_reg;
  logic [OPW-1:0]     b_reg;
  logic [OPW-1:0]     sum_reg;
  logic               carry_reg;

  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W-1:0] s_slice;
  logic               rca_cout;

  logic [OPW-1:0]     b_load;
  logic               c_load;

  // Subtraction is A + ~B + 1, so only the B operand and initial carry change
`ifdef RCA_SEQ_SUB_EN
  assign b_load = in_sub ? ~in_b : in_b;
  assign c_load = in_sub | in_cin;
`else
  assign b_load = in_b;
  assign c_load = in_cin;
`endif

  // Select the operand slices addressed by the current slice index
  always_comb begin
    a_slice = a_reg[SLICE_W-1:0];
    b_slice = b_reg[SLICE_W-1:0];
    for (int i = 0; i < NSLICE; i++) begin
      if (idx == IDX_W'(i)) begin
        a_slice = a_reg[i*SLICE_W +: SLICE_W];
        b_slice = b_reg[i*SLICE_W +: SLICE_W];
      end
    end
  end

  rca_seq_ctrl_rca #(
    .WIDTH (SLICE_W)
  ) u_rca (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_reg),
    .sum  (s_slice),
    .cout (rca_cout)
  );

  // Controller FSM with operand/result registers and registered handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_reg     <= in_a;
            b_reg     <= b_load;
            carry_reg <= c_load;
            idx       <= '0;
            in_ready  <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
              sum_reg[i*SLICE_W +: SLICE_W] <= s_slice;
            end
          end
          carry_reg <= rca_cout;
          if (idx == IDX_LAST) begin
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = carry_reg;

endmodule
`default_nettype wire
